ecc_mult_arbiter: RTL and testbench
===================================

# ecc_mult_arbiter

Round-robin arbiter and sequencer that shares one scalar point-multiplication engine (the `dotProduct` core: `Px`, `Py`, `k` in, `Rx`, `Ry` out) among `NUM_REQ` requesters. It accepts one request at a time over a valid/ready handshake and holds the operands. It then pulses the engine's `in_valid`, waits for `out_valid`, and returns the result to the owning requester over a valid/ready response channel. The block sits between the protocol-level clients (signing, key agreement) and the single engine instance.

## Interface
- `DATA_WIDTH`, 256: coordinate and scalar width.
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 20'hFFFFF: watchdog limit in cycles. Used only with `ECC_ARB_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester request valid.
- `req_ready` out NUM_REQ: one-hot accept. Combinational.
- `req_Px` in NUM_REQ*DATA_WIDTH: packed operands. Requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]. Same packing for `req_Py` and `req_k`.
- `req_Py` in NUM_REQ*DATA_WIDTH.
- `req_k` in NUM_REQ*DATA_WIDTH.
- `rsp_valid` out NUM_REQ: one-hot response valid. Registered.
- `rsp_ready` in NUM_REQ: per-requester response accept.
- `rsp_Rx` out DATA_WIDTH: result, shared bus.
- `rsp_Ry` out DATA_WIDTH: result, shared bus.
- `rsp_err` out 1: response is a timeout (0 when the macro is off).
- `busy` out 1: high in every state except IDLE.
- `eng_Px`, `eng_Py`, `eng_k` out DATA_WIDTH each: engine operands, driven from the holding registers.
- `eng_in_valid` out 1: one-cycle start pulse. Registered.
- `eng_Rx` in DATA_WIDTH, `eng_Ry` in DATA_WIDTH, `eng_out_valid` in 1: engine result, valid for the one cycle `eng_out_valid` is high.

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN (DRAIN exists only with the macro).
- IDLE
  - If any `req_valid` is set, grant the first set bit at or after `rr_ptr`, searching upward with wrap-around.
  - `req_ready[g]` is high in the same cycle.
  - On that edge: latch the operands of requester g into the holding registers, record g, set `rr_ptr` to (g+1) mod NUM_REQ, go to ISSUE.
- ISSUE
  - `eng_in_valid`=1 for exactly this one cycle. The engine samples the operands on this cycle.
  - Go to WAIT.
- WAIT
  - On `eng_out_valid`, capture `eng_Rx`/`eng_Ry` into `rsp_Rx`/`rsp_Ry`, set `rsp_err`=0, go to RESP.
- RESP
  - `rsp_valid[g]`=1.
  - Hold `rsp_valid`, `rsp_Rx`, `rsp_Ry` and `rsp_err` stable until `rsp_ready[g]`.
  - On that edge: clear `rsp_valid`, go to IDLE (or to DRAIN if a timeout is pending).
  - `rsp_ready` bits other than g are ignored.
- `req_ready` is 0 in every state other than IDLE. No new request is accepted in the cycle a response completes.
- A requester that drops `req_valid` before it is granted loses nothing. A requester whose `req_valid` stays high is served within NUM_REQ grants (round-robin fairness).
- An `eng_out_valid` that arrives outside WAIT or DRAIN is ignored.
- `eng_Px`, `eng_Py`, `eng_k` are continuously driven from the holding registers. The holding registers reset to 0.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_Rx`=0, `rsp_Ry`=0, `rsp_err`=0, `eng_in_valid`=0, `busy`=0, `rr_ptr`=0, state=IDLE.
- Asserting reset at any point aborts the current transaction immediately. The engine must be reset on the same `rst_n`.
- Latency, with accept on cycle 0:
  - `eng_in_valid` high on cycle 1.
  - If `eng_out_valid` is high on cycle T, `rsp_valid` is high from cycle T+1.
  - With immediate `rsp_ready`, the earliest next accept is cycle T+2.
- Back-to-back engine starts are therefore at least 3 cycles apart, which covers the engine's DONE to IDLE recovery.

## Configuration
- `ECC_ARB_TIMEOUT_EN` defined: adds a watchdog.
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` without `eng_out_valid`, go to RESP with `rsp_err`=1 and `rsp_Rx`=`rsp_Ry`=0.
  - After the response handshake, enter DRAIN instead of IDLE. DRAIN discards the late `eng_out_valid` and then goes to IDLE. `busy` stays 1 throughout.
  - If `eng_out_valid` and the timeout occur in the same cycle, the result wins: normal response with `rsp_err`=0.
- `ECC_ARB_TIMEOUT_EN` undefined: no counter and no DRAIN state. WAIT waits indefinitely and `rsp_err` is tied to 0.

## Test plan
- Single request, NUM_REQ=4, requester 2, Px=0x11, Py=0x22, k=0x3, engine model with latency 20 that returns Rx=0xAA, Ry=0xBB -> `req_ready`=4'b0100 on cycle 0, `eng_in_valid` on cycle 1 with `eng_k`=0x3, `rsp_valid`=4'b0100 on cycle 22 with Rx=0xAA, Ry=0xBB.
- All four requesters hold `req_valid` high continuously -> grants in order 0,1,2,3,0, exactly one `eng_in_valid` per grant, and each response routed to the matching requester.
- `rsp_ready` held low for 10 cycles during RESP -> `rsp_valid`, `rsp_Rx`, `rsp_Ry` stable for all 10 cycles and `req_ready` stays 0. Accept resumes 1 cycle after the handshake.
- `rst_n` pulsed low during WAIT -> all outputs return to reset values asynchronously and `rr_ptr`=0. A subsequent request from requester 3 is granted normally.
- With the macro, TIMEOUT_CYCLES=50, engine never responds -> `rsp_valid` with `rsp_err`=1 and Rx=Ry=0 at WAIT cycle 50. DRAIN then swallows a late `eng_out_valid`, and the next request completes with `rsp_err`=0.
- Spurious `eng_out_valid` pulse while in IDLE -> no `rsp_valid`, and the state is unchanged.

Source files
------------

// File: rtl/ecc_mult_arbiter.sv
// rtl/ecc_mult_arbiter.sv - round-robin arbiter/sequencer sharing one point-multiplication engine
// Optional watchdog and DRAIN state enabled by defining ECC_ARB_TIMEOUT_EN.
module ecc_mult_arbiter #(
    parameter int          DATA_WIDTH     = 256,
    parameter int          NUM_REQ        = 4,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'hFFFFF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_Px,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_Py,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_k,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_Rx,
    output logic [DATA_WIDTH-1:0]         rsp_Ry,
    output logic                          rsp_err,
    output logic                          busy,
    output logic [DATA_WIDTH-1:0]         eng_Px,
    output logic [DATA_WIDTH-1:0]         eng_Py,
    output logic [DATA_WIDTH-1:0]         eng_k,
    output logic                          eng_in_valid,
    input  logic [DATA_WIDTH-1:0]         eng_Rx,
    input  logic [DATA_WIDTH-1:0]         eng_Ry,
    input  logic                          eng_out_valid
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef ECC_ARB_TIMEOUT_EN
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;
    logic [19:0] cnt_q;
    logic        rsp_err_q;
`else
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
`endif

    state_t                  state_q;
    logic [PTR_W-1:0]        rr_ptr_q;
    logic [PTR_W-1:0]        owner_q;
    logic [DATA_WIDTH-1:0]   px_q, py_q, k_q;
    logic [DATA_WIDTH-1:0]   rsp_rx_q, rsp_ry_q;
    logic [NUM_REQ-1:0]      rsp_valid_q;
    logic                    eng_in_valid_q;

    logic                    grant_found;
    logic [PTR_W-1:0]        grant_idx;
    logic [PTR_W-1:0]        next_ptr_d;
    int unsigned             cand;

    // First requesting index at or after rr_ptr_q, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(cand);
            end
        end
        next_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + PTR_W'(1);
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state_q == S_IDLE) && grant_found && (grant_idx == PTR_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            rr_ptr_q       <= '0;
            owner_q        <= '0;
            px_q           <= '0;
            py_q           <= '0;
            k_q            <= '0;
            rsp_rx_q       <= '0;
            rsp_ry_q       <= '0;
            rsp_valid_q    <= '0;
            eng_in_valid_q <= 1'b0;
`ifdef ECC_ARB_TIMEOUT_EN
            cnt_q          <= '0;
            rsp_err_q      <= 1'b0;
`endif
        end else begin
            eng_in_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        px_q           <= req_Px[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                        py_q           <= req_Py[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                        k_q            <= req_k[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                        owner_q        <= grant_idx;
                        rr_ptr_q       <= next_ptr_d;
                        eng_in_valid_q <= 1'b1;
                        state_q        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
`ifdef ECC_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                S_WAIT: begin
                    // A result arriving on the timeout cycle still wins.
                    if (eng_out_valid) begin
                        rsp_rx_q    <= eng_Rx;
                        rsp_ry_q    <= eng_Ry;
                        rsp_valid_q <= NUM_REQ'(1) << owner_q;
                        state_q     <= S_RESP;
`ifdef ECC_ARB_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
                    end else if (cnt_q == TIMEOUT_CYCLES - 20'd1) begin
                        rsp_rx_q    <= '0;
                        rsp_ry_q    <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= NUM_REQ'(1) << owner_q;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q       <= cnt_q + 20'd1;
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready[owner_q]) begin
                        rsp_valid_q <= '0;
`ifdef ECC_ARB_TIMEOUT_EN
                        state_q     <= rsp_err_q ? S_DRAIN : S_IDLE;
`else
                        state_q     <= S_IDLE;
`endif
                    end
                end
`ifdef ECC_ARB_TIMEOUT_EN
                S_DRAIN: begin
                    if (eng_out_valid) state_q <= S_IDLE;
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_Rx       = rsp_rx_q;
    assign rsp_Ry       = rsp_ry_q;
    assign busy         = (state_q != S_IDLE);
    assign eng_Px       = px_q;
    assign eng_Py       = py_q;
    assign eng_k        = k_q;
    assign eng_in_valid = eng_in_valid_q;
`ifdef ECC_ARB_TIMEOUT_EN
    assign rsp_err      = rsp_err_q;
`else
    assign rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_mult_arbiter.sv
// tb/tb_ecc_mult_arbiter.sv - randomized self-checking bench for ecc_mult_arbiter
// Engine behaviour and grant order come from a behavioural model kept in the bench.
module tb_ecc_mult_arbiter;
    localparam int DW = 256;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
    logic [NR*DW-1:0] req_Px = '0, req_Py = '0, req_k = '0;
    logic [DW-1:0]    rsp_Rx, rsp_Ry, eng_Px, eng_Py, eng_k;
    logic [DW-1:0]    eng_Rx, eng_Ry;
    logic             rsp_err, busy, eng_in_valid, eng_out_valid;
    logic             eng_ov_model, spur = 1'b0;
    assign eng_out_valid = eng_ov_model | spur;

    ecc_mult_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT_CYCLES(20'd50)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_Px(req_Px), .req_Py(req_Py), .req_k(req_k),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_Rx(rsp_Rx), .rsp_Ry(rsp_Ry), .rsp_err(rsp_err), .busy(busy),
        .eng_Px(eng_Px), .eng_Py(eng_Py), .eng_k(eng_k), .eng_in_valid(eng_in_valid),
        .eng_Rx(eng_Rx), .eng_Ry(eng_Ry), .eng_out_valid(eng_out_valid)
    );

    int n_vec = 0, n_err = 0;
    int eng_lat = 5, eng_cnt = 0, model_ptr = 0;
    bit eng_silent = 1'b0, fixed_mode = 1'b0;
    logic [DW-1:0] px [NR], py [NR], kk [NR];
    logic [DW-1:0] lat_px, lat_py, lat_k;

    function automatic logic [DW-1:0] f_rx(input logic [DW-1:0] p, input logic [DW-1:0] k);
        return p ^ (k << 3);
    endfunction
    function automatic logic [DW-1:0] f_ry(input logic [DW-1:0] p, input logic [DW-1:0] k);
        return p + k;
    endfunction
    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction
    function automatic int model_grant(input logic [NR-1:0] mask);
        for (int i = 0; i < NR; i++) if (mask[(model_ptr + i) % NR]) return (model_ptr + i) % NR;
        return -1;
    endfunction
    function automatic logic [NR-1:0] onehot(input int g);
        logic [NR-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    // Engine model: result appears eng_lat cycles after the start pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_cnt = 0;
            eng_ov_model <= 1'b0;
            eng_Rx <= '0;
            eng_Ry <= '0;
        end else begin
            eng_ov_model <= 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt = eng_cnt - 1;
                if (eng_cnt == 0) begin
                    eng_ov_model <= 1'b1;
                    eng_Rx <= fixed_mode ? DW'(8'hAA) : f_rx(lat_px, lat_k);
                    eng_Ry <= fixed_mode ? DW'(8'hBB) : f_ry(lat_py, lat_k);
                end
            end
            if (eng_in_valid && !eng_silent) begin
                eng_cnt = eng_lat - 1;
                lat_px = eng_Px;
                lat_py = eng_Py;
                lat_k  = eng_k;
            end
        end
    end

    task automatic load_ops(input bit randomize_ops);
        for (int i = 0; i < NR; i++) begin
            if (randomize_ops) begin
                px[i] = rnd();
                py[i] = rnd();
                kk[i] = rnd();
            end
            req_Px[i*DW +: DW] = px[i];
            req_Py[i*DW +: DW] = py[i];
            req_k[i*DW +: DW]  = kk[i];
        end
    endtask

    task automatic do_txn(input logic [NR-1:0] mask, input int lat, input int hold,
                          input logic [NR-1:0] bg, input bit randomize_ops);
        int g, cyc;
        logic [DW-1:0] exp_rx, exp_ry;
        load_ops(randomize_ops);
        g = model_grant(mask);
        exp_rx = fixed_mode ? DW'(8'hAA) : f_rx(px[g], kk[g]);
        exp_ry = fixed_mode ? DW'(8'hBB) : f_ry(py[g], kk[g]);
        @(posedge clk); #1;
        req_valid = mask;
        eng_lat = lat;
        rsp_ready = '0;
        @(negedge clk);
        n_vec++;
        if (req_ready !== onehot(g)) begin n_err++; $display("FAIL grant act=%b exp=%b", req_ready, onehot(g)); end
        model_ptr = (g + 1) % NR;
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        n_vec++;
        if (eng_in_valid !== 1'b1 || eng_Px !== px[g] || eng_Py !== py[g] || eng_k !== kk[g] || busy !== 1'b1) begin
            n_err++; $display("FAIL issue act_iv=%b act_k=%h exp_k=%h", eng_in_valid, eng_k, kk[g]);
        end
        cyc = 1;
        while (rsp_valid === '0 && cyc < 300) begin
            @(negedge clk);
            if (eng_in_valid !== 1'b0) begin n_vec++; n_err++; $display("FAIL extra_start act=%b exp=0", eng_in_valid); end
            cyc++;
        end
        n_vec++;
        if (cyc !== lat + 2) begin n_err++; $display("FAIL rsp_latency act=%0d exp=%0d", cyc, lat + 2); end
        n_vec++;
        if (rsp_valid !== onehot(g) || rsp_Rx !== exp_rx || rsp_Ry !== exp_ry || rsp_err !== 1'b0) begin
            n_err++; $display("FAIL rsp_data act_v=%b exp_v=%b act_rx=%h exp_rx=%h", rsp_valid, onehot(g), rsp_Rx, exp_rx);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            req_valid = bg;
            rsp_ready = NR'($urandom) & ~onehot(g);
            @(negedge clk);
            n_vec++;
            if (rsp_valid !== onehot(g) || rsp_Rx !== exp_rx || rsp_Ry !== exp_ry || req_ready !== '0) begin
                n_err++; $display("FAIL rsp_hold cyc=%0d act_v=%b act_rdy=%b exp_v=%b", h, rsp_valid, req_ready, onehot(g));
            end
        end
        @(posedge clk); #1;
        rsp_ready = NR'($urandom) | onehot(g);
        @(posedge clk); #1;
        rsp_ready = '0;
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== '0) begin n_err++; $display("FAIL rsp_clear act=%b exp=0", rsp_valid); end
        n_vec++;
        if (bg != '0) begin
            if (req_ready !== onehot(model_grant(bg))) begin
                n_err++; $display("FAIL resume act=%b exp=%b", req_ready, onehot(model_grant(bg)));
            end
            req_valid = '0;
        end else if (busy !== 1'b0) begin
            n_err++; $display("FAIL idle_busy act=%b exp=0", busy);
        end
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if (req_ready !== '0 || rsp_valid !== '0 || rsp_Rx !== '0 || rsp_Ry !== '0 ||
            rsp_err !== 1'b0 || eng_in_valid !== 1'b0 || busy !== 1'b0 || eng_k !== '0) begin
            n_err++; $display("FAIL reset_vals act_v=%b act_busy=%b exp=0", rsp_valid, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        px[2] = DW'(8'h11);
        py[2] = DW'(8'h22);
        kk[2] = DW'(8'h3);
        fixed_mode = 1'b1;
        do_txn(4'b0100, 20, 0, '0, 1'b0);
        fixed_mode = 1'b0;
    endtask

    task automatic test_back_to_back();
        int e, cyc, pulses;
        load_ops(1'b1);
        @(posedge clk); #1;
        req_valid = '1;
        rsp_ready = '1;
        for (int n = 0; n < 5; n++) begin
            e = model_grant('1);
            cyc = 0;
            @(negedge clk);
            while (req_ready === '0 && cyc < 50) begin @(negedge clk); cyc++; end
            n_vec++;
            if (req_ready !== onehot(e) || cyc !== 0) begin
                n_err++; $display("FAIL rr_grant n=%0d act=%b exp=%b gap=%0d", n, req_ready, onehot(e), cyc);
            end
            model_ptr = (e + 1) % NR;
            eng_lat = $urandom_range(2, 6);
            pulses = 0;
            cyc = 0;
            do begin
                @(negedge clk);
                if (eng_in_valid === 1'b1) pulses++;
                cyc++;
            end while (rsp_valid === '0 && cyc < 100);
            n_vec++;
            if (pulses !== 1) begin n_err++; $display("FAIL start_count act=%0d exp=1", pulses); end
            n_vec++;
            if (rsp_valid !== onehot(e) || rsp_Rx !== f_rx(px[e], kk[e]) || rsp_Ry !== f_ry(py[e], kk[e])) begin
                n_err++; $display("FAIL rr_route act=%b exp=%b", rsp_valid, onehot(e));
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = '0;
    endtask

    task automatic test_rsp_hold();
        do_txn(4'b0001, 4, 10, 4'b1010, 1'b1);
    endtask

    task automatic test_spurious();
        @(posedge clk); #1;
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (rsp_valid !== '0 || busy !== 1'b0) begin
                n_err++; $display("FAIL spurious act_v=%b act_busy=%b exp=0", rsp_valid, busy);
            end
        end
        do_txn(4'b0110, 3, 0, '0, 1'b1);
    endtask

    task automatic test_random();
        logic [NR-1:0] m;
        for (int n = 0; n < 20; n++) begin
            m = NR'($urandom_range(1, (1 << NR) - 1));
            do_txn(m, $urandom_range(2, 12), $urandom_range(0, 3), '0, 1'b1);
        end
    endtask

    task automatic test_reset_midflight();
        load_ops(1'b1);
        @(posedge clk); #1;
        req_valid = 4'b0010;
        eng_lat = 30;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || rsp_valid !== '0 || eng_in_valid !== 1'b0 || rsp_Rx !== '0 ||
            req_ready !== '0 || eng_Px !== '0) begin
            n_err++; $display("FAIL async_reset act_busy=%b act_v=%b exp=0", busy, rsp_valid);
        end
        model_ptr = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_txn(4'b1010, 5, 0, '0, 1'b1);
        do_txn(4'b1000, 5, 0, '0, 1'b1);
    endtask

`ifdef ECC_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int cyc, g;
        load_ops(1'b1);
        g = model_grant(4'b0001);
        eng_silent = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b0001;
        @(posedge clk); #1;
        req_valid = '0;
        model_ptr = (g + 1) % NR;
        @(negedge clk);
        cyc = 1;
        while (rsp_valid === '0 && cyc < 300) begin @(negedge clk); cyc++; end
        n_vec++;
        if (cyc !== 52 || rsp_err !== 1'b1 || rsp_Rx !== '0 || rsp_Ry !== '0 || rsp_valid !== onehot(g)) begin
            n_err++; $display("FAIL timeout act_cyc=%0d exp=52 act_err=%b", cyc, rsp_err);
        end
        @(posedge clk); #1;
        rsp_ready = onehot(g);
        @(posedge clk); #1;
        rsp_ready = '0;
        eng_silent = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b1 || rsp_valid !== '0) begin n_err++; $display("FAIL drain_busy act=%b exp=1", busy); end
        @(posedge clk); #1;
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL drain_exit act=%b exp=0", busy); end
        do_txn(4'b0100, 4, 0, '0, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_rsp_hold();
        test_spurious();
        test_random();
        test_reset_midflight();
`ifdef ECC_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
